fns_dec_seq: RTL and testbench

- Parametrised, multi-cycle Fibonacci-numeral-system (FNS) decoder for the CAC receive path.
- Converts a CODE_W-bit FNS codeword to binary by accumulating Fibonacci weights STEP bits per cycle, LSB first.
- Weights are generated on the fly, so no weight table is stored.
- Sits between the bus-side code capture register and the data sink, with valid/ready on both sides.

---
 rtl/fns_dec_seq.sv | 138 +++++++++++++
 tb/tb_fns_dec_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fns_dec_seq.sv
// Multi-cycle Fibonacci-numeral-system decoder: accumulates Fibonacci weights STEP bits per cycle, LSB first.
// Optional non-canonical codeword detection is built when FNS_DEC_CHK_EN is defined.
module fns_dec_seq #(
  parameter int unsigned CODE_W = 23,
  parameter int unsigned STEP   = 1,
  parameter int unsigned OUT_W  = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  dataout,
  output logic              code_err
);

  localparam int unsigned IDX_W = $clog2(CODE_W + STEP + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] sh_q;
  logic [OUT_W-1:0]  acc_q, wa_q, wb_q;
  logic [IDX_W-1:0]  idx_q;

  logic              accept_c, last_c;
  logic [OUT_W-1:0]  step_sum_c, acc_next_c, wa_next_c, wb_next_c;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_c = in_valid && in_ready;
  assign last_c   = (state_q == RUN) && ((32'(idx_q) + STEP) >= CODE_W);

  // Weighted sum of this step's bits; weights roll forward from the current pair.
  always_comb begin
    logic [OUT_W-1:0]  a, b, t;
    logic [CODE_W-1:0] shv;
    step_sum_c = '0;
    a   = wa_q;
    b   = wb_q;
    t   = '0;
    shv = '0;
    for (int unsigned j = 0; j < STEP; j++) begin
      shv = sh_q >> j;
      if (((32'(idx_q) + j) < CODE_W) && shv[0]) begin
        step_sum_c = step_sum_c + a;
      end
      t = a + b;
      a = b;
      b = t;
    end
    wa_next_c  = a;
    wb_next_c  = b;
    acc_next_c = acc_q + step_sum_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = RUN;
      RUN:  if (last_c) state_d = DONE;
      DONE: if (out_ready) state_d = accept_c ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q      <= '0;
      acc_q     <= '0;
      wa_q      <= OUT_W'(1);
      wb_q      <= OUT_W'(2);
      idx_q     <= '0;
      out_valid <= 1'b0;
      dataout   <= '0;
    end else if (accept_c) begin
      sh_q      <= codein;
      acc_q     <= '0;
      wa_q      <= OUT_W'(1);
      wb_q      <= OUT_W'(2);
      idx_q     <= '0;
      out_valid <= 1'b0;
    end else if (state_q == RUN) begin
      sh_q  <= sh_q >> STEP;
      acc_q <= acc_next_c;
      wa_q  <= wa_next_c;
      wb_q  <= wb_next_c;
      idx_q <= idx_q + IDX_W'(STEP);
      if (last_c) begin
        dataout   <= acc_next_c;
        out_valid <= 1'b1;
      end
    end else if ((state_q == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FNS_DEC_CHK_EN
  logic err_q, err_step_c;

  // Adjacent-ones check; sh[STEP] is the next step's first bit, covering straddling pairs.
  always_comb begin
    logic [CODE_W:0] shx;
    err_step_c = 1'b0;
    shx        = '0;
    for (int unsigned j = 0; j < STEP; j++) begin
      shx = {1'b0, sh_q} >> j;
      if (((32'(idx_q) + j + 1) < CODE_W) && shx[0] && shx[1]) begin
        err_step_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      code_err <= 1'b0;
    end else if (accept_c) begin
      err_q <= 1'b0;
    end else if (state_q == RUN) begin
      err_q <= err_q | err_step_c;
      if (last_c) code_err <= err_q | err_step_c;
    end
  end
`else
  assign code_err = 1'b0;
`endif

endmodule

// File: tb/tb_fns_dec_seq.sv
// Scoreboard bench for fns_dec_seq: default build (STEP=1) and a STEP=4 instance sharing clock/reset.
module tb_fns_dec_seq;

  localparam int unsigned CW = 23;
  localparam int unsigned OW = 17;
`ifdef FNS_DEC_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iv0, ir0, ov0, or0, ce0;
  logic          iv1, ir1, ov1, or1, ce1;
  logic [CW-1:0] ci0, ci1;
  logic [OW-1:0] do0, do1;

  always #5 clk = ~clk;

  fns_dec_seq #(.CODE_W(CW), .STEP(1), .OUT_W(OW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .codein(ci0),
    .out_valid(ov0), .out_ready(or0), .dataout(do0), .code_err(ce0)
  );

  fns_dec_seq #(.CODE_W(CW), .STEP(4), .OUT_W(OW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .codein(ci1),
    .out_valid(ov1), .out_ready(or1), .dataout(do1), .code_err(ce1)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic          e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t x0, x1;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: compare every completed output handshake against the queue head.
  always @(negedge clk) begin
    if (rst_n && ov0 && or0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0_unexpected: got %0d expected no result", do0);
      end else begin
        x0 = q0.pop_front();
        chk("sb0_data", 32'(do0), 32'(x0.d));
        chk("sb0_err", 32'(ce0), 32'(x0.e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_unexpected: got %0d expected no result", do1);
      end else begin
        x1 = q1.pop_front();
        chk("sb1_data", 32'(do1), 32'(x1.d));
        chk("sb1_err", 32'(ce1), 32'(x1.e));
      end
    end
  end

  // Present a codeword, wait (bounded) for acceptance, optionally measure latency to out_valid.
  task automatic send(input bit s, input logic [CW-1:0] c, input logic [OW-1:0] d,
                      input logic e, input int lat, output int waited);
    int n;
    if (s) begin iv1 = 1'b1; ci1 = c; end
    else   begin iv0 = 1'b1; ci0 = c; end
    n = 0;
    forever begin
      @(negedge clk);
      if (s ? ir1 : ir0) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1");
        break;
      end
    end
    waited = n;
    if (s) q1.push_back(exp_t'({d, e}));
    else   q0.push_back(exp_t'({d, e}));
    @(posedge clk); #1;
    if (s) iv1 = 1'b0;
    else   iv0 = 1'b0;
    if (lat > 0) begin
      n = 0;
      while (!(s ? ov1 : ov0) && n < lat + 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk(s ? "latency1" : "latency0", 32'(n), 32'(lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    iv0 = 1'b0; iv1 = 1'b0; ci0 = '0; ci1 = '0; or0 = 1'b1; or1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov0", 32'(ov0), 0);
    chk("rst_do0", 32'(do0), 0);
    chk("rst_ce0", 32'(ce0), 0);
    chk("rst_ir0", 32'(ir0), 1);
    chk("rst_ov1", 32'(ov1), 0);
    rst_n = 1'b1;

    // STEP=1 directed vectors
    send(0, 23'h000000, 17'd0,      1'b0, 23, w);
    send(0, 23'h000005, 17'd4,      1'b0, 23, w);
    send(0, 23'h400000, 17'd46368,  1'b0, 0,  w);
    send(0, 23'h7FFFFF, 17'd121391, CHK,  0,  w);
    send(0, 23'h000003, 17'd3,      CHK,  23, w);
    @(posedge clk); #1;

    // Output stall: result must hold while sink is not ready
    or0 = 1'b0;
    send(0, 23'h000024, 17'd16, 1'b0, 23, w);
    for (int i = 0; i < 10; i++) begin
      chk("stall_ov", 32'(ov0), 1);
      chk("stall_do", 32'(do0), 16);
      chk("stall_ir", 32'(ir0), 0);
      @(posedge clk); #1;
    end
    or0 = 1'b1;
    send(0, 23'h000001, 17'd1, 1'b0, 23, w);
    chk("b2b_wait", 32'(w), 0);

    // Asynchronous reset during RUN discards the in-flight codeword
    send(0, 23'h7FFFFF, 17'd121391, CHK, 0, w);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(ov0), 0);
    chk("arst_do", 32'(do0), 0);
    chk("arst_ce", 32'(ce0), 0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("arst_ir", 32'(ir0), 1);
    send(0, 23'h000002, 17'd2, 1'b0, 23, w);

    // STEP=4 instance, including a pair straddling a step boundary
    send(1, 23'h0AAAAA, 17'd17710,  1'b0, 6, w);
    send(1, 23'h000018, 17'd13,     CHK,  6, w);
    send(1, 23'h7FFFFF, 17'd121391, CHK,  6, w);
    send(1, 23'h400001, 17'd46369,  1'b0, 6, w);

    repeat (5) @(posedge clk);
    #1;
    chk("drain_q0", 32'(q0.size()), 0);
    chk("drain_q1", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
